// File: rtl/serial_add_sub_pkg.sv
// Shared FSM state encodings and operation-mode constants for the bit-serial
// adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/FullAdder.sv
// Single-bit full-adder cell: sum and carry-out from two operand bits and a
// carry-in.
module FullAdder (
  input  logic i_A,
  input  logic i_B,
  input  logic i_Cin,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_A ^ i_B ^ i_Cin;
  assign o_carry = (i_A & i_B) | (i_A & i_Cin) | (i_B & i_Cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor, one bit per clock LSB first through a single
// FullAdder slice. Define SERIAL_ADD_SUB_ZERO_FLAG_EN to add the o_zero output.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  output logic             o_zero,
`endif
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             ovf_q, ovf_d;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif
  logic             fa_sum_s;
  logic             fa_carry_s;

  FullAdder u_fa (
    .i_A    (a_sr_q[0]),
    .i_B    (b_sr_q[0]),
    .i_Cin  (carry_q),
    .o_sum  (fa_sum_s),
    .o_carry(fa_carry_s)
  );

  // Next-state, datapath shift and result capture
  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_sr_d    = res_sr_q;
    carry_d     = carry_q;
    count_d     = count_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = ST_SHIFT;
          a_sr_d  = i_A;
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          b_sr_d  = i_B ^ {WIDTH{i_sub}};
          carry_d = (i_sub == OP_SUB) ? 1'b1 : 1'b0;
          count_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = {fa_sum_s, res_sr_q[WIDTH-1:1]};
        carry_d  = fa_carry_s;
        count_d  = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d     = ST_DONE;
          result_d    = res_sr_d;
          carry_out_d = fa_carry_s;
          // carry_q here is the carry into the MSB; overflow when it differs from carry-out.
          ovf_d       = carry_q ^ fa_carry_s;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
          zero_d      = (res_sr_d == '0);
`endif
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_sr_q    <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_sr_q    <= res_sr_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_valid    = (state_q == ST_DONE);
  assign o_result   = result_q;
  assign o_carry    = carry_out_q;
  assign o_overflow = ovf_q;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  assign o_zero     = zero_q;
`endif

endmodule
